// File: rtl/cadence_meas.sv
// cadence_meas: synchronizes and debounces the raw pedal cadence sensor,
// counts filtered rising edges over a fixed power-of-two window, and flags
// the rider as stationary after a run of empty windows.
module cadence_meas #(
   parameter int DB_BITS   = 8,
   parameter int WIN_BITS  = 22,
   parameter int STALL_WIN = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cadence_raw,
   output logic [4:0] cadence,
   output logic       not_pedaling,
   output logic       cadence_vld
);

   // zero_cnt must hold STALL_WIN; the increment gets one extra bit so it never wraps
   localparam int          ZW        = $clog2(STALL_WIN + 1);
   localparam logic [ZW:0] STALL_LIM = (ZW + 1)'(STALL_WIN);

   function automatic logic [4:0] sat31(input logic [5:0] v);
      return (v > 6'd31) ? 5'd31 : v[4:0];
   endfunction

   logic                sync1_q, sync1_d;
   logic                sync2_q, sync2_d;
   logic                filt_q, filt_d;
   logic                filt_dly_q, filt_dly_d;   // one-clock delay of filt for edge detect
   logic [DB_BITS-1:0]  db_cnt_q, db_cnt_d;
   logic [WIN_BITS-1:0] win_cnt_q, win_cnt_d;
   logic [4:0]          edge_cnt_q, edge_cnt_d;
   logic [ZW-1:0]       zero_cnt_q, zero_cnt_d;
   logic [4:0]          cadence_q, cadence_d;
   logic                not_ped_q, not_ped_d;
   logic                vld_q, vld_d;

   logic                rise;
   logic                win_end;
   logic [4:0]          cap;
   logic [ZW:0]         zero_inc;

   // Next-state logic: sync chain, debounce, edge counting, window capture and stall tracking
   always_comb begin
      sync1_d    = cadence_raw;
      sync2_d    = sync1_q;
      filt_d     = filt_q;
      filt_dly_d = filt_q;
      db_cnt_d   = db_cnt_q;
      win_cnt_d  = win_cnt_q + WIN_BITS'(1);
      edge_cnt_d = edge_cnt_q;
      zero_cnt_d = zero_cnt_q;
      cadence_d  = cadence_q;
      not_ped_d  = not_ped_q;
      vld_d      = 1'b0;

      rise     = filt_q & ~filt_dly_q;
      win_end  = &win_cnt_q;
      cap      = sat31({1'b0, edge_cnt_q} + {5'b0, rise});
      zero_inc = {1'b0, zero_cnt_q} + (ZW + 1)'(1);

      // A disagreement must persist for the full counter span; any agreement restarts it
      if (sync2_q == filt_q) begin
         db_cnt_d = '0;
      end else if (&db_cnt_q) begin
         filt_d   = sync2_q;
         db_cnt_d = '0;
      end else begin
         db_cnt_d = db_cnt_q + DB_BITS'(1);
      end

      if (win_end) begin
         // A rise on the closing clock belongs to the closing window (already in cap)
         edge_cnt_d = '0;
         cadence_d  = cap;
         vld_d      = 1'b1;
         if (cap == 5'd0) begin
            zero_cnt_d = (zero_inc >= STALL_LIM) ? STALL_LIM[ZW-1:0] : zero_inc[ZW-1:0];
            not_ped_d  = (zero_inc >= STALL_LIM);
         end else begin
            zero_cnt_d = '0;
            not_ped_d  = 1'b0;
         end
      end else begin
         edge_cnt_d = sat31({1'b0, edge_cnt_q} + {5'b0, rise});
      end
   end

   // State registers; reset treats the bike as stationary and discards any partial window
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         filt_q     <= 1'b0;
         filt_dly_q <= 1'b0;
         db_cnt_q   <= '0;
         win_cnt_q  <= '0;
         edge_cnt_q <= '0;
         zero_cnt_q <= '0;
         cadence_q  <= '0;
         not_ped_q  <= 1'b1;
         vld_q      <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         filt_q     <= filt_d;
         filt_dly_q <= filt_dly_d;
         db_cnt_q   <= db_cnt_d;
         win_cnt_q  <= win_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         zero_cnt_q <= zero_cnt_d;
         cadence_q  <= cadence_d;
         not_ped_q  <= not_ped_d;
         vld_q      <= vld_d;
      end
   end

   assign cadence      = cadence_q;
   assign not_pedaling = not_ped_q;
   assign cadence_vld  = vld_q;

endmodule

// File: tb/tb_cadence_meas.sv
// Testbench for cadence_meas: window-level vector table with an expectation
// queue for the 8-bit-window instance, plus hand-written sequences on a
// 9-bit-window instance for saturation and the window-end boundary.
module tb_cadence_meas;

   logic       clk;
   logic       rst, raw, vld, np;
   logic [4:0] cad;
   logic       rst9, raw9, vld9, np9;
   logic [4:0] cad9;

   int  period, hi;
   bit  restart_tog;
   int  n_chk, n_pass;

   typedef struct {int period; int hi; int cad; int np;} rec_t;
   typedef struct {int cad; int np; int idx;} exp_t;

   rec_t tbl[17];
   exp_t exp_q[$];

   cadence_meas #(.DB_BITS(2), .WIN_BITS(8), .STALL_WIN(2)) dut (
      .clk(clk), .rst(rst), .cadence_raw(raw),
      .cadence(cad), .not_pedaling(np), .cadence_vld(vld)
   );

   cadence_meas #(.DB_BITS(2), .WIN_BITS(9), .STALL_WIN(2)) dut9 (
      .clk(clk), .rst(rst9), .cadence_raw(raw9),
      .cadence(cad9), .not_pedaling(np9), .cadence_vld(vld9)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Square-wave generator for the 8-bit-window instance; period 0 holds the input low
   initial begin
      int ph;
      bit seen;
      ph = 0;
      seen = 1'b0;
      raw = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (restart_tog != seen) begin
            seen = restart_tog;
            ph = 0;
         end
         if (period == 0) begin
            raw = 1'b0;
         end else begin
            raw = (ph < hi);
            ph = (ph + 1) % period;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic sb_push(input int c, input int n, input int idx);
      exp_t e;
      e.cad = c;
      e.np  = n;
      e.idx = idx;
      exp_q.push_back(e);
   endtask

   task automatic sb_pop();
      exp_t e;
      if (exp_q.size() == 0) begin
         n_chk++;
         $display("FAIL sb_unexpected_vld: got cadence_vld with cadence=%0d, expected no update", cad);
      end else begin
         e = exp_q.pop_front();
         check($sformatf("win%0d_cadence", e.idx), int'(cad), e.cad);
         check($sformatf("win%0d_not_pedaling", e.idx), int'(np), e.np);
      end
   endtask

   task automatic wait_vld(output int cyc);
      bit got;
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (vld) begin
            got = 1'b1;
            sb_pop();
         end
      end
      if (!got) begin
         n_chk++;
         $display("FAIL vld_timeout: no cadence_vld after %0d clocks, expected one within 256", cyc);
      end
   endtask

   initial begin
      int cyc;
      int nw;
      n_chk = 0;
      n_pass = 0;
      period = 0;
      hi = 0;
      restart_tog = 1'b0;
      rst = 1'b1;
      rst9 = 1'b1;
      raw9 = 1'b0;

      //            period hi  cadence not_pedaling
      tbl[0]  = '{32,  16,  8, 0};
      tbl[1]  = '{32,  16,  8, 0};
      tbl[2]  = '{32,  16,  8, 0};
      tbl[3]  = '{64,  32,  4, 0};
      tbl[4]  = '{64,  32,  4, 0};
      tbl[5]  = '{16,   8, 16, 0};
      tbl[6]  = '{128, 64,  2, 0};
      tbl[7]  = '{256, 128, 1, 0};
      tbl[8]  = '{20,   3,  0, 0};
      tbl[9]  = '{20,   3,  0, 1};
      tbl[10] = '{20,   3,  0, 1};
      tbl[11] = '{32,  16,  8, 0};
      tbl[12] = '{0,    0,  0, 0};
      tbl[13] = '{0,    0,  0, 1};
      tbl[14] = '{0,    0,  0, 1};
      tbl[15] = '{32,  16,  8, 0};
      tbl[16] = '{32,  16,  8, 0};

      // Reset values while rst is held
      repeat (3) @(negedge clk);
      check("rst_cadence", int'(cad), 0);
      check("rst_not_pedaling", int'(np), 1);
      check("rst_vld", int'(vld), 0);
      check("rst9_not_pedaling", int'(np9), 1);
      repeat (2) @(negedge clk);

      // First window with the input idle: one zero window is below the stall threshold
      sb_push(0, 0, -1);
      rst = 1'b0;
      repeat (100) @(negedge clk);
      check("prewin_cadence", int'(cad), 0);
      check("prewin_not_pedaling", int'(np), 1);
      check("prewin_vld", int'(vld), 0);
      wait_vld(cyc);
      check("first_vld_clock", cyc + 100, 256);

      // Window-by-window vector table; each pattern change restarts on a window boundary
      for (int i = 0; i < 17; i++) begin
         if (tbl[i].period != period || tbl[i].hi != hi) begin
            period = tbl[i].period;
            hi = tbl[i].hi;
            restart_tog = ~restart_tog;
         end
         sb_push(tbl[i].cad, tbl[i].np, i);
         wait_vld(cyc);
         check($sformatf("win%0d_spacing", i), cyc, 256);
      end

      // One-clock reset at win_cnt=100 while pedaling continues
      repeat (100) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_cadence", int'(cad), 0);
      check("midrst_not_pedaling", int'(np), 1);
      check("midrst_vld", int'(vld), 0);
      rst = 1'b0;
      sb_push(8, 0, 17);
      wait_vld(cyc);
      check("midrst_vld_clock", cyc, 256);
      check("sb_leftover", exp_q.size(), 0);

      // Saturation: period-10 pedaling gives ~51 edges per 512-clock window
      rst9 = 1'b0;
      nw = 0;
      for (int i = 0; i < 1540; i++) begin
         raw9 = ((i % 10) < 5);
         @(negedge clk);
         if (vld9) begin
            nw++;
            check($sformatf("sat_win%0d_cadence", nw), int'(cad9), 31);
            check($sformatf("sat_win%0d_not_pedaling", nw), int'(np9), 0);
         end
      end
      check("sat_window_count", nw, 3);

      // Boundary: a filtered rise landing exactly on the window-end clock
      raw9 = 1'b0;
      cyc = 0;
      while (!vld9 && cyc < 600) begin
         @(negedge clk);
         cyc++;
      end
      if (!vld9) begin
         n_chk++;
         $display("FAIL bnd_sync_timeout: no cadence_vld after %0d clocks, expected one within 512", cyc);
      end
      repeat (505) @(negedge clk);
      raw9 = 1'b1;
      repeat (6) @(negedge clk);
      check("bnd_vld_early", int'(vld9), 0);
      @(negedge clk);
      check("bnd_close_vld", int'(vld9), 1);
      check("bnd_close_cadence", int'(cad9), 1);
      check("bnd_close_not_pedaling", int'(np9), 0);
      repeat (512) @(negedge clk);
      check("bnd_next_vld", int'(vld9), 1);
      check("bnd_next_cadence", int'(cad9), 0);
      check("bnd_next_not_pedaling", int'(np9), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
